// File: rtl/conv_tap_sequencer.sv
// Time-multiplexed 3x3 convolution tap sequencer: one shared multiplier, nine taps
// issued one per cycle, 20-bit accumulation, shadow/active coefficient banks.
module conv_tap_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        win_valid,
  output logic        win_ready,
  input  logic [71:0] win_data,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [7:0]  coef_wdata,
  input  logic        coef_commit,
  output logic        coef_pending,
  output logic [7:0]  mul_op1,
  output logic [7:0]  mul_op2,
  input  logic [15:0] mul_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [19:0] out_sum,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  // Tracking pattern when only the final product remains in the multiplier pipe.
  localparam logic [MUL_LAT-1:0] TRK_LAST = MUL_LAT'(1) << (MUL_LAT - 1);

  logic [1:0]         state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [19:0]        acc_q, acc_d;
  logic [MUL_LAT-1:0] trk_q, trk_d;
  logic [71:0]        win_q, win_d;
  logic [71:0]        shadow_q, shadow_d;
  logic [71:0]        active_q, active_d;
  logic               pending_q, pending_d;
  logic               copy;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    trk_d     = trk_q << 1;
    win_d     = win_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    win_ready = 1'b0;
    mul_op1   = '0;
    mul_op2   = '0;
    out_valid = 1'b0;
    out_sum   = '0;
    copy      = (state_q == S_IDLE) && pending_q;

    if (trk_q[MUL_LAT-1]) begin
      acc_d = acc_q + {4'b0000, mul_res};
    end

    case (state_q)
      S_IDLE: begin
        win_ready = !pending_q;
        if (win_valid && !pending_q) begin
          win_d   = win_data;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_op1 = active_q[k_q*8 +: 8];
        mul_op2 = win_q[k_q*8 +: 8];
        trk_d   = (trk_q << 1) | MUL_LAT'(1);
        k_d     = k_q + 4'd1;
        if (k_q == 4'd8) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (trk_q == TRK_LAST) begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_sum   = acc_q;
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The copy reads the registered shadow, so a same-cycle write lands in shadow only.
    if (coef_we && (coef_addr <= 4'd8)) begin
      shadow_d[coef_addr*8 +: 8] = coef_wdata;
    end
    if (copy) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (coef_commit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      acc_q     <= '0;
      trk_q     <= '0;
      win_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      trk_q     <= trk_d;
      win_q     <= win_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign coef_pending = pending_q;

endmodule

// File: tb/tb_conv_tap_sequencer.sv
// Randomized self-checking bench for conv_tap_sequencer (MUL_LAT 1 and 3 instances)
// against a kernel/window reference model and behavioural multipliers.
module tb_conv_tap_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        win_valid = 1'b0, win_valid3 = 1'b0;
  logic [71:0] win_data = '0;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [7:0]  coef_wdata = '0;
  logic        coef_commit = 1'b0;
  logic        out_ready = 1'b1, out_ready3 = 1'b1;

  logic        win_ready, coef_pending, out_valid, busy;
  logic [7:0]  mul_op1, mul_op2;
  logic [19:0] out_sum;
  logic [15:0] res1 = '0;

  logic        win_ready3, coef_pending3, out_valid3, busy3;
  logic [7:0]  op1_3, op2_3;
  logic [19:0] out_sum3;
  logic [15:0] pipe3 [3];
  logic [15:0] res3;

  int checks = 0;
  int fails  = 0;
  int model_shadow [9];
  int model_active [9];
  bit model_pending = 1'b0;
  logic [7:0] seen_op1 [9];
  logic [7:0] seen_op2 [9];

  conv_tap_sequencer #(.MUL_LAT(1)) u_dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .coef_pending(coef_pending), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_res(res1),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .busy(busy)
  );

  conv_tap_sequencer #(.MUL_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .win_valid(win_valid3), .win_ready(win_ready3), .win_data(win_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_commit(coef_commit),
    .coef_pending(coef_pending3), .mul_op1(op1_3), .mul_op2(op2_3), .mul_res(res3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_sum(out_sum3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // Behavioural multipliers with one and three cycles of latency.
  always @(posedge clk) begin
    res1     <= mul_op1 * mul_op2;
    pipe3[0] <= op1_3 * op2_3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign res3 = pipe3[2];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply();
    if (model_pending) begin
      for (int i = 0; i < 9; i++) model_active[i] = model_shadow[i];
      model_pending = 1'b0;
    end
  endtask

  function automatic int model_sum(input logic [71:0] d);
    int s = 0;
    for (int i = 0; i < 9; i++) s += model_active[i] * int'(d[i*8 +: 8]);
    return s;
  endfunction

  function automatic logic [71:0] rand_window();
    logic [71:0] d;
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'($urandom_range(255, 0));
    return d;
  endfunction

  task automatic drive_coef(input bit we, input int addr, input int data, input bit commit);
    coef_we     = we;
    coef_addr   = addr[3:0];
    coef_wdata  = data[7:0];
    coef_commit = commit;
    tick();
    coef_we     = 1'b0;
    coef_commit = 1'b0;
    if (we && addr >= 0 && addr < 9) model_shadow[addr] = data;
    if (commit) model_pending = 1'b1;
  endtask

  task automatic load_kernel_random();
    for (int i = 0; i < 9; i++) drive_coef(1'b1, i, int'($urandom_range(255, 1)), i == 8);
  endtask

  // Offers a window and returns once it has been accepted (or the wait expired).
  task automatic offer(input logic [71:0] d);
    int n = 0;
    win_data  = d;
    win_valid = 1'b1;
    while (!win_ready && n < 30) begin
      tick();
      n++;
    end
    model_apply();
    tick();
    win_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat, output int sum);
    int c = start;
    while (!out_valid && c < 60) begin
      if (c >= 1 && c <= 9) begin
        seen_op1[c-1] = mul_op1;
        seen_op2[c-1] = mul_op2;
      end
      tick();
      c++;
    end
    lat = c;
    sum = int'(out_sum);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++; if (win_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_win_ready: got %b expected 1", win_ready); end
    checks++; if (coef_pending !== 1'b0) begin fails++; $display("[TB] FAIL reset_coef_pending: got %b expected 0", coef_pending); end
    checks++; if (mul_op1 !== 8'd0 || mul_op2 !== 8'd0) begin fails++; $display("[TB] FAIL reset_mul_ops: got %0d/%0d expected 0/0", mul_op1, mul_op2); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 20'd0) begin fails++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_identity();
    logic [71:0] d;
    int lat, sum;
    drive_coef(1'b1, 0, 1, 1'b0);
    for (int i = 1; i < 9; i++) drive_coef(1'b1, i, 0, i == 8);
    checks++; if (coef_pending !== 1'b1 || win_ready !== 1'b0) begin fails++; $display("[TB] FAIL copy_cycle: got pending=%b ready=%b expected pending=1 ready=0", coef_pending, win_ready); end
    tick();
    checks++; if (coef_pending !== 1'b0 || win_ready !== 1'b1) begin fails++; $display("[TB] FAIL after_copy: got pending=%b ready=%b expected pending=0 ready=1", coef_pending, win_ready); end
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'd7;
    d[7:0] = 8'd200;
    offer(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== 200) begin fails++; $display("[TB] FAIL identity_sum: got %0d expected 200", sum); end
    checks++; if (lat !== 11) begin fails++; $display("[TB] FAIL identity_latency: got %0d expected 11", lat); end
    handshake();
  endtask

  task automatic test_worst_case();
    logic [71:0] d;
    int lat, sum, c;
    for (int i = 0; i < 9; i++) drive_coef(1'b1, i, 255, i == 8);
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'd255;
    offer(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== 585225 || sum !== model_sum(d)) begin fails++; $display("[TB] FAIL worst_sum: got %0d expected 585225", sum); end
    checks++; if (lat !== 11) begin fails++; $display("[TB] FAIL worst_latency: got %0d expected 11", lat); end
    handshake();
    c = 0;
    win_valid3 = 1'b1;
    while (!win_ready3 && c < 30) begin tick(); c++; end
    tick();
    win_valid3 = 1'b0;
    c = 1;
    while (!out_valid3 && c < 60) begin tick(); c++; end
    checks++; if (out_sum3 !== 20'd585225) begin fails++; $display("[TB] FAIL worst_sum_lat3: got %0d expected 585225", out_sum3); end
    checks++; if (c !== 13) begin fails++; $display("[TB] FAIL worst_latency_lat3: got %0d expected 13", c); end
    tick();
  endtask

  task automatic test_commit_during_window();
    logic [71:0] d;
    int lat, sum, exp;
    for (int i = 0; i < 9; i++) drive_coef(1'b1, i, 1, i == 8);
    for (int i = 0; i < 9; i++) d[i*8 +: 8] = 8'(i + 1);
    offer(d);
    exp = model_sum(d);
    for (int i = 0; i < 9; i++) drive_coef(1'b1, i, 2, i == 8);
    checks++; if (coef_pending !== 1'b1 || busy !== 1'b1) begin fails++; $display("[TB] FAIL pending_while_busy: got pending=%b busy=%b expected 1/1", coef_pending, busy); end
    wait_out(10, lat, sum);
    checks++; if (sum !== 45 || sum !== exp) begin fails++; $display("[TB] FAIL commit_first_sum: got %0d expected 45", sum); end
    checks++; if (lat !== 11) begin fails++; $display("[TB] FAIL commit_first_latency: got %0d expected 11", lat); end
    checks++; if (coef_pending !== 1'b1) begin fails++; $display("[TB] FAIL pending_at_out: got %b expected 1", coef_pending); end
    handshake();
    checks++; if (win_ready !== 1'b0 || coef_pending !== 1'b1) begin fails++; $display("[TB] FAIL idle_copy_cycle: got ready=%b pending=%b expected 0/1", win_ready, coef_pending); end
    offer(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== 90 || sum !== model_sum(d)) begin fails++; $display("[TB] FAIL commit_second_sum: got %0d expected 90", sum); end
    handshake();
  endtask

  task automatic test_back_pressure();
    logic [71:0] d1, d2;
    int lat, sum, exp1, exp2;
    load_kernel_random();
    d1 = rand_window();
    d2 = rand_window();
    out_ready = 1'b0;
    offer(d1);
    exp1 = model_sum(d1);
    win_data  = d2;
    win_valid = 1'b1;
    wait_out(1, lat, sum);
    checks++; if (sum !== exp1) begin fails++; $display("[TB] FAIL bp_sum: got %0d expected %0d", sum, exp1); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== 20'(exp1) || win_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL bp_stall: got valid=%b sum=%0d ready=%b expected 1/%0d/0", out_valid, out_sum, win_ready, exp1);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (win_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL bp_release_idle: got ready=%b busy=%b expected 1/0", win_ready, busy); end
    exp2 = model_sum(d2);
    tick();
    win_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL bp_next_accept: got busy=%b expected 1", busy); end
    wait_out(1, lat, sum);
    checks++; if (sum !== exp2 || lat !== 11) begin fails++; $display("[TB] FAIL bp_second: got sum=%0d lat=%0d expected %0d/11", sum, lat, exp2); end
    handshake();
  endtask

  task automatic test_invalid_write();
    logic [71:0] d;
    int lat, sum, exp;
    drive_coef(1'b1, 12, 8'hAA, 1'b0);
    drive_coef(1'b0, 0, 0, 1'b1);
    d = rand_window();
    offer(d);
    exp = model_sum(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== exp) begin fails++; $display("[TB] FAIL invalid_write_sum: got %0d expected %0d", sum, exp); end
    handshake();
  endtask

  task automatic test_copy_cycle_write();
    logic [71:0] d;
    int lat, sum, exp;
    drive_coef(1'b1, 3, 77, 1'b1);
    model_apply();
    drive_coef(1'b1, 3, 5, 1'b0);
    d = rand_window();
    offer(d);
    exp = model_sum(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== exp) begin fails++; $display("[TB] FAIL copy_write_old: got %0d expected %0d", sum, exp); end
    handshake();
    drive_coef(1'b0, 0, 0, 1'b1);
    offer(d);
    exp = model_sum(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== exp) begin fails++; $display("[TB] FAIL copy_write_new: got %0d expected %0d", sum, exp); end
    handshake();
  endtask

  task automatic test_random();
    logic [71:0] d;
    int lat, sum, exp, errs;
    for (int r = 0; r < 4; r++) begin
      load_kernel_random();
      for (int w = 0; w < 2; w++) begin
        d = rand_window();
        offer(d);
        exp = model_sum(d);
        wait_out(1, lat, sum);
        checks++; if (sum !== exp || lat !== 11) begin fails++; $display("[TB] FAIL random_window: got sum=%0d lat=%0d expected %0d/11", sum, lat, exp); end
        errs = 0;
        for (int i = 0; i < 9; i++) begin
          if (seen_op1[i] !== 8'(model_active[i]) || seen_op2[i] !== d[i*8 +: 8]) errs++;
        end
        checks++; if (errs !== 0) begin fails++; $display("[TB] FAIL random_operands: got %0d wrong taps expected 0", errs); end
        handshake();
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] d;
    int lat, sum;
    load_kernel_random();
    offer(rand_window());
    repeat (4) tick();
    rst = 1'b0;
    #2;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || win_ready !== 1'b1) begin fails++; $display("[TB] FAIL midreset_ctrl: got busy=%b valid=%b ready=%b expected 0/0/1", busy, out_valid, win_ready); end
    checks++; if (mul_op1 !== 8'd0 || mul_op2 !== 8'd0 || coef_pending !== 1'b0 || out_sum !== 20'd0) begin fails++; $display("[TB] FAIL midreset_data: got op1=%0d op2=%0d pending=%b sum=%0d expected zeros", mul_op1, mul_op2, coef_pending, out_sum); end
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 9; i++) begin model_shadow[i] = 0; model_active[i] = 0; end
    model_pending = 1'b0;
    tick();
    d = rand_window();
    d[7:0] = 8'd99;
    offer(d);
    wait_out(1, lat, sum);
    checks++; if (sum !== 0 || sum !== model_sum(d)) begin fails++; $display("[TB] FAIL midreset_sum: got %0d expected 0", sum); end
    checks++; if (lat !== 11) begin fails++; $display("[TB] FAIL midreset_latency: got %0d expected 11", lat); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_identity();
    test_worst_case();
    test_commit_during_window();
    test_back_pressure();
    test_invalid_write();
    test_copy_cycle_write();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/conv_tap_sequencer.md
# conv_tap_sequencer

Time-multiplexed controller for the 3x3 convolution stage. It shares one `multiplier8bit16` instance across all nine taps instead of instantiating one multiplier per tap. It accepts a 3x3 pixel window through a valid/ready handshake, issues the nine coefficient×pixel products one per cycle, and accumulates the returned products into a 20-bit sum. It also owns the kernel coefficient store, which has a shadow bank and an active bank so the kernel can be reprogrammed without corrupting a window that is in flight.

## Interface
- `MUL_LAT`, default 1: cycles from operands presented at `mul_op1`/`mul_op2` to the matching `mul_res`. Legal range is 1..4.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `win_valid` in 1: a pixel window is offered.
- `win_ready` out 1: the block accepts the window this cycle.
- `win_data` in 72: packed pixels p1..p9; p1 = [7:0], p9 = [71:64].
- `coef_we` in 1: write one shadow coefficient.
- `coef_addr` in 4: shadow index 0..8. Values 9..15 are ignored, with no write.
- `coef_wdata` in 8: coefficient value, unsigned.
- `coef_commit` in 1: request copy of the shadow bank into the active bank.
- `coef_pending` out 1: a commit has been requested and not yet applied.
- `mul_op1` out 8: coefficient operand to the multiplier.
- `mul_op2` out 8: pixel operand to the multiplier.
- `mul_res` in 16: product returned by the multiplier.
- `out_valid` out 1: `out_sum` is valid.
- `out_ready` in 1: the downstream stage accepts `out_sum`.
- `out_sum` out 20: Σ c_i·p_i over i = 1..9. The maximum is 585225, so no overflow is possible.
- `busy` out 1: the FSM is not in IDLE.

## Operation
- **FSM states:** IDLE, ISSUE, DRAIN, OUT.
- **IDLE:**
  - `win_ready` = 1 unless a commit is applied this cycle.
  - On `win_valid && win_ready`: latch `win_data`, clear the accumulator, set tap index k = 0, go to ISSUE.
- **ISSUE:**
  - Present `mul_op1` = active[k] and `mul_op2` = p(k+1).
  - Push a 1 into a MUL_LAT-deep issue-tracking shift register.
  - k increments each cycle. When k = 8, go to DRAIN.
- **DRAIN:**
  - `mul_op1` and `mul_op2` = 0. Push 0 into the tracking register.
  - Leave DRAIN for OUT on the cycle the last tracked product is accumulated.
- **Accumulation:**
  - Whenever the tracking register output is 1, `acc <= acc + mul_res` (zero-extended to 20 bits).
  - This happens in ISSUE and in DRAIN.
- **OUT:**
  - `out_valid` = 1 and `out_sum` = acc. Both are held stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE.
  - There is no bypass: a new window is accepted no earlier than the cycle after the output handshake.
- **Operand outputs:** `mul_op1`/`mul_op2` are 0 in every state except ISSUE.
- **Coefficients:**
  - `coef_we` writes shadow[coef_addr] in any state.
  - `coef_commit` sets `coef_pending`.
  - While `coef_pending` = 1 and the FSM is in IDLE, all nine shadow entries are copied to the active bank in one cycle, and `coef_pending` clears.
  - In that copy cycle `win_ready` = 0, so the copy never coincides with a window accept.
  - The active bank never changes while `busy` = 1.
- **Simultaneous coefficient events:**
  - A `coef_we` in the same cycle as the copy updates shadow only; it is not part of that copy.
  - A `coef_commit` while `coef_pending` is already 1 has no additional effect.
- **Reset (mid-operation included):**
  - FSM returns to IDLE. Accumulator, tracking register, window latch, shadow bank and active bank all clear to 0.
  - Any partial result is discarded, and in-flight multiplier results are ignored.

## Timing
- **Reset values:**
  - `win_ready` = 1 on the first cycle after reset release.
  - `coef_pending`, `mul_op1`, `mul_op2`, `out_valid`, `out_sum` and `busy` = 0.
- **Window accept at cycle 0:**
  - ISSUE runs cycles 1..9, presenting tap k on cycle k+1.
  - Tap k's product is valid on cycle k+1+MUL_LAT.
  - The last product is accumulated at the end of cycle 9+MUL_LAT.
  - `out_valid` rises on cycle 10+MUL_LAT. This is 11 cycles for MUL_LAT = 1.
- **Throughput:** with `out_ready` held at 1, one window every 11+MUL_LAT cycles.
- **Output stall:** `out_valid` stays high while `out_ready` = 0, with `out_sum` unchanged; `win_ready` stays 0 throughout.
- **Commit while busy:** a commit requested while `busy` = 1 is applied in the first IDLE cycle. Any window offered in that cycle is accepted one cycle later.

## Test plan
- **Identity kernel:** reset, write shadow = {1,0,0,0,0,0,0,0,0}, commit, then offer a window p1 = 200, others 7 -> `out_sum` = 200, with `out_valid` on cycle 11 after accept (MUL_LAT = 1).
- **Worst case:** all coefficients 255, all pixels 255 -> `out_sum` = 585225 with no wrap. Repeat with MUL_LAT = 3 -> `out_valid` at cycle 13.
- **Commit during a window:** coefficients all 1, pixels 1..9; during ISSUE, write all shadow entries to 2 and commit -> first `out_sum` = 45. `coef_pending` stays 1 until IDLE, `win_ready` = 0 for that one cycle. The next window (same pixels) -> `out_sum` = 90.
- **Back-pressure:** hold `out_ready` = 0 for 5 cycles with `win_valid` = 1 -> `out_sum` stable, `win_ready` = 0. Release `out_ready` -> handshake, then the next window is accepted one cycle later.
- **Invalid write:** `coef_we` with `coef_addr` = 12 -> no shadow change; a subsequent commit leaves the prior kernel intact.
- **Reset mid-operation:** assert `rst` low at ISSUE tap 4 -> all outputs at reset values, active bank = 0. The next window returns `out_sum` = 0.
